// File: rtl/spi_frame_sched_pkg.sv
// Shared SPI definitions: phase lane modes, segment directions, sequencer
// states and the size-code to bit-count helper.
package spi_frame_sched_pkg;

  localparam logic [1:0] PHASE_STD  = 2'b00;
  localparam logic [1:0] PHASE_DUAL = 2'b01;
  localparam logic [1:0] PHASE_QUAD = 2'b10;
  localparam logic [1:0] PHASE_NONE = 2'b11;

  localparam logic [1:0] DIR_TX    = 2'b00;
  localparam logic [1:0] DIR_RX    = 2'b01;
  localparam logic [1:0] DIR_DUMMY = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_ALTR,
    ST_DUMMY,
    ST_DATA,
    ST_RXPUSH,
    ST_FINISH
  } state_t;

  // Size code 00/01/10/11 -> 8/16/24/32 bits.
  function automatic logic [15:0] size_bits(input logic [1:0] sz);
    case (sz)
      2'b00:   return 16'd8;
      2'b01:   return 16'd16;
      2'b10:   return 16'd24;
      default: return 16'd32;
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_sched.sv
// SPI frame phase sequencer: walks CMD/ADDR/ALTR/DUMMY/DATA, issues one
// segment per phase (one per word in DATA), moves FIFO data and frames CS.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start_i, CS inactive
// CMD       | 8-bit command segment
// ADDR      | address segment, 8..32 bits
// ALTR      | alternate-byte segment, 8..32 bits
// DUMMY     | nop SCK cycles, nothing shifted
// DATA      | one data word per segment, TX pops or RX pushes
// RXPUSH    | holding a received word until the RX FIFO has room
// FINISH    | one-cycle done pulse, CS already dropped
module spi_frame_sched
  import spi_frame_sched_pkg::*;
#(
  parameter int FIFO_DW = 32,
  parameter int TRL_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         cmode_i,
  input  logic [1:0]         amode_i,
  input  logic [1:0]         almode_i,
  input  logic [1:0]         dmode_i,
  input  logic [1:0]         asize_i,
  input  logic [1:0]         alsize_i,
  input  logic [1:0]         dsize_i,
  input  logic [15:0]        cmd_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        altr_i,
  input  logic [15:0]        nop_i,
  input  logic [TRL_W-1:0]   trl_i,
  input  logic               rwm_i,
  output logic               seg_valid_o,
  input  logic               seg_ready_i,
  input  logic               seg_done_i,
  output logic [FIFO_DW-1:0] seg_data_o,
  output logic [15:0]        seg_len_o,
  output logic [1:0]         seg_lane_o,
  output logic [1:0]         seg_dir_o,
  input  logic [FIFO_DW-1:0] seg_rdata_i,
  input  logic               txf_empty_i,
  output logic               txf_rd_o,
  input  logic [FIFO_DW-1:0] txf_data_i,
  input  logic               rxf_full_i,
  output logic               rxf_wr_o,
  output logic [FIFO_DW-1:0] rxf_data_o,
  output logic               cs_o,
  output logic               busy_o,
  output logic               done_o
);

  state_t             state;
  logic               issued;
  logic [TRL_W-1:0]   cnt;
  logic [FIFO_DW-1:0] rx_hold;

  // frame shadow copies
  logic [1:0]       cmode_s, amode_s, almode_s, dmode_s;
  logic [1:0]       asize_s, alsize_s, dsize_s;
  logic [7:0]       cmd_s;
  logic [31:0]      addr_s, altr_s;
  logic [15:0]      nop_s;
  logic [TRL_W-1:0] trl_s;
  logic             rwm_s;

  // configuration as seen this cycle: live inputs while idle, shadows otherwise
  logic [1:0]       c_cmode, c_amode, c_almode, c_dmode;
  logic [1:0]       c_asize, c_alsize, c_dsize;
  logic [7:0]       c_cmd;
  logic [31:0]      c_addr, c_altr;
  logic [15:0]      c_nop;
  logic [TRL_W-1:0] c_trl;
  logic             c_rwm;

  state_t             tgt;
  logic               advance;
  logic               tgt_valid;
  logic [1:0]         tgt_dir, tgt_lane;
  logic [15:0]        tgt_len;
  logic [FIFO_DW-1:0] tgt_data;

  logic unused_cmd_hi;
  assign unused_cmd_hi = ^cmd_i[15:8];

  function automatic state_t first_phase(input logic [2:0] from, input logic cmd_on,
                                         input logic addr_on, input logic altr_on,
                                         input logic dummy_on, input logic data_on);
    if (from == 3'd0 && cmd_on)   return ST_CMD;
    if (from <= 3'd1 && addr_on)  return ST_ADDR;
    if (from <= 3'd2 && altr_on)  return ST_ALTR;
    if (from <= 3'd3 && dummy_on) return ST_DUMMY;
    if (from <= 3'd4 && data_on)  return ST_DATA;
    return ST_FINISH;
  endfunction

  function automatic logic [FIFO_DW-1:0] mask_sz(input logic [FIFO_DW-1:0] d,
                                                 input logic [1:0] sz);
    logic [FIFO_DW-1:0] m;
    logic [15:0]        n;
    n = size_bits(sz);
    for (int i = 0; i < FIFO_DW; i++) m[i] = d[i] & (i < int'(n));
    return m;
  endfunction

  // select live or shadow configuration
  always_comb begin
    if (state == ST_IDLE) begin
      c_cmode = cmode_i;  c_amode = amode_i;  c_almode = almode_i; c_dmode = dmode_i;
      c_asize = asize_i;  c_alsize = alsize_i; c_dsize = dsize_i;
      c_cmd   = cmd_i[7:0]; c_addr = addr_i; c_altr = altr_i;
      c_nop   = nop_i;    c_trl = trl_i;       c_rwm = rwm_i;
    end else begin
      c_cmode = cmode_s;  c_amode = amode_s;  c_almode = almode_s; c_dmode = dmode_s;
      c_asize = asize_s;  c_alsize = alsize_s; c_dsize = dsize_s;
      c_cmd   = cmd_s;    c_addr = addr_s;     c_altr = altr_s;
      c_nop   = nop_s;    c_trl = trl_s;       c_rwm = rwm_s;
    end
  end

  // next phase to enter and whether this cycle moves there
  always_comb begin
    logic data_on;
    data_on = (c_dmode != PHASE_NONE) && (c_trl != '0);
    tgt     = ST_FINISH;
    advance = 1'b0;
    case (state)
      ST_IDLE: begin
        tgt     = first_phase(3'd0, c_cmode != PHASE_NONE, c_amode != PHASE_NONE,
                              c_almode != PHASE_NONE, c_nop != '0, data_on);
        advance = start_i;
      end
      ST_CMD, ST_ADDR, ST_ALTR, ST_DUMMY: begin
        case (state)
          ST_CMD:  tgt = first_phase(3'd1, 1'b0, c_amode != PHASE_NONE,
                                     c_almode != PHASE_NONE, c_nop != '0, data_on);
          ST_ADDR: tgt = first_phase(3'd2, 1'b0, 1'b0, c_almode != PHASE_NONE,
                                     c_nop != '0, data_on);
          ST_ALTR: tgt = first_phase(3'd3, 1'b0, 1'b0, 1'b0, c_nop != '0, data_on);
          default: tgt = first_phase(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, data_on);
        endcase
        advance = issued && seg_done_i;
      end
      ST_DATA: begin
        tgt     = (cnt == TRL_W'(1)) ? ST_FINISH : ST_DATA;
        advance = issued && seg_done_i && !(c_rwm && rxf_full_i);
      end
      ST_RXPUSH: begin
        tgt     = (cnt == '0) ? ST_FINISH : ST_DATA;
        advance = !rxf_full_i;
      end
      default: begin
        tgt     = ST_FINISH;
        advance = 1'b0;
      end
    endcase
  end

  // segment descriptor for the phase about to be entered
  always_comb begin
    tgt_valid = 1'b1;
    tgt_dir   = DIR_TX;
    tgt_lane  = PHASE_STD;
    tgt_len   = 16'd8;
    tgt_data  = '0;
    case (tgt)
      ST_CMD: begin
        tgt_lane = c_cmode;
        tgt_data = FIFO_DW'(c_cmd);
      end
      ST_ADDR: begin
        tgt_lane = c_amode;
        tgt_len  = size_bits(c_asize);
        tgt_data = mask_sz(FIFO_DW'(c_addr), c_asize);
      end
      ST_ALTR: begin
        tgt_lane = c_almode;
        tgt_len  = size_bits(c_alsize);
        tgt_data = mask_sz(FIFO_DW'(c_altr), c_alsize);
      end
      ST_DUMMY: begin
        tgt_dir = DIR_DUMMY;
        tgt_len = c_nop;
      end
      ST_DATA: begin
        tgt_lane = c_dmode;
        tgt_len  = size_bits(c_dsize);
        if (c_rwm) begin
          tgt_dir = DIR_RX;
        end else begin
          tgt_valid = !txf_empty_i;
          tgt_data  = mask_sz(txf_data_i, c_dsize);
        end
      end
      default: tgt_valid = 1'b0;
    endcase
  end

  // pop happens in the handshake cycle of a DATA write segment
  assign txf_rd_o = seg_valid_o & seg_ready_i & (state == ST_DATA) & ~rwm_s & ~abort_i;

  // sequencer state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      issued      <= 1'b0;
      cnt         <= '0;
      rx_hold     <= '0;
      cmode_s     <= '0; amode_s  <= '0; almode_s <= '0; dmode_s <= '0;
      asize_s     <= '0; alsize_s <= '0; dsize_s  <= '0;
      cmd_s       <= '0; addr_s   <= '0; altr_s   <= '0;
      nop_s       <= '0; trl_s    <= '0; rwm_s    <= 1'b0;
      seg_valid_o <= 1'b0;
      seg_data_o  <= '0;
      seg_len_o   <= '0;
      seg_lane_o  <= '0;
      seg_dir_o   <= '0;
      rxf_wr_o    <= 1'b0;
      rxf_data_o  <= '0;
      cs_o        <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      rxf_wr_o <= 1'b0;
      done_o   <= 1'b0;
      if (state != ST_IDLE && abort_i) begin
        state       <= ST_IDLE;
        issued      <= 1'b0;
        seg_valid_o <= 1'b0;
        cs_o        <= 1'b0;
        busy_o      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              cmode_s  <= cmode_i;  amode_s  <= amode_i;  almode_s <= almode_i;
              dmode_s  <= dmode_i;  asize_s  <= asize_i;  alsize_s <= alsize_i;
              dsize_s  <= dsize_i;  cmd_s    <= cmd_i[7:0];
              addr_s   <= addr_i;   altr_s   <= altr_i;
              nop_s    <= nop_i;    trl_s    <= trl_i;    rwm_s    <= rwm_i;
              cnt      <= trl_i;
              issued   <= 1'b0;
              busy_o   <= 1'b1;
            end
          end
          ST_CMD, ST_ADDR, ST_ALTR, ST_DUMMY, ST_DATA: begin
            if (!issued) begin
              if (seg_valid_o && seg_ready_i) begin
                seg_valid_o <= 1'b0;
                issued      <= 1'b1;
              end else if (state == ST_DATA && !rwm_s && !seg_valid_o) begin
                // TX FIFO was empty: offer the segment as soon as a word shows up
                seg_valid_o <= !txf_empty_i;
                seg_data_o  <= mask_sz(txf_data_i, dsize_s);
              end
            end else if (seg_done_i) begin
              issued <= 1'b0;
              if (state == ST_DATA) begin
                cnt <= cnt - TRL_W'(1);
                if (rwm_s) begin
                  if (rxf_full_i) begin
                    rx_hold <= seg_rdata_i;
                    state   <= ST_RXPUSH;
                  end else begin
                    rxf_wr_o   <= 1'b1;
                    rxf_data_o <= seg_rdata_i;
                  end
                end
              end
            end
          end
          ST_RXPUSH: begin
            if (!rxf_full_i) begin
              rxf_wr_o   <= 1'b1;
              rxf_data_o <= rx_hold;
            end
          end
          ST_FINISH: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
        if (advance) begin
          state <= tgt;
          if (tgt == ST_FINISH) begin
            done_o      <= 1'b1;
            cs_o        <= 1'b0;
            seg_valid_o <= 1'b0;
          end else begin
            cs_o        <= 1'b1;
            seg_valid_o <= tgt_valid;
            seg_dir_o   <= tgt_dir;
            seg_lane_o  <= tgt_lane;
            seg_len_o   <= tgt_len;
            seg_data_o  <= tgt_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_sched.sv
// Directed bench for spi_frame_sched with a simple shift-engine and FIFO model.
module tb_spi_frame_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, abort_i;
  logic [1:0]  cmode_i, amode_i, almode_i, dmode_i;
  logic [1:0]  asize_i, alsize_i, dsize_i;
  logic [15:0] cmd_i;
  logic [31:0] addr_i, altr_i;
  logic [15:0] nop_i;
  logic [15:0] trl_i;
  logic        rwm_i;
  logic        seg_valid_o;
  logic        seg_ready_i = 1'b0;
  logic        seg_done_i = 1'b0;
  logic [31:0] seg_data_o;
  logic [15:0] seg_len_o;
  logic [1:0]  seg_lane_o, seg_dir_o;
  logic [31:0] seg_rdata_i = '0;
  logic        txf_empty_i;
  logic        txf_rd_o;
  logic [31:0] txf_data_i;
  logic        rxf_full_i;
  logic        rxf_wr_o;
  logic [31:0] rxf_data_o;
  logic        cs_o, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  spi_frame_sched #(.FIFO_DW(32), .TRL_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .cmode_i(cmode_i), .amode_i(amode_i), .almode_i(almode_i), .dmode_i(dmode_i),
    .asize_i(asize_i), .alsize_i(alsize_i), .dsize_i(dsize_i),
    .cmd_i(cmd_i), .addr_i(addr_i), .altr_i(altr_i), .nop_i(nop_i),
    .trl_i(trl_i), .rwm_i(rwm_i),
    .seg_valid_o(seg_valid_o), .seg_ready_i(seg_ready_i), .seg_done_i(seg_done_i),
    .seg_data_o(seg_data_o), .seg_len_o(seg_len_o), .seg_lane_o(seg_lane_o),
    .seg_dir_o(seg_dir_o), .seg_rdata_i(seg_rdata_i),
    .txf_empty_i(txf_empty_i), .txf_rd_o(txf_rd_o), .txf_data_i(txf_data_i),
    .rxf_full_i(rxf_full_i), .rxf_wr_o(rxf_wr_o), .rxf_data_o(rxf_data_o),
    .cs_o(cs_o), .busy_o(busy_o), .done_o(done_o)
  );

  // TX FIFO model: main writes tx_wr, engine advances tx_rd
  logic [31:0] tx_mem [0:15];
  logic [7:0]  tx_wr = 8'd0;
  logic [7:0]  tx_rd = 8'd0;
  assign txf_empty_i = (tx_rd == tx_wr);
  assign txf_data_i  = tx_mem[tx_rd[3:0]];

  // engine model state and logs
  logic        eng_busy = 1'b0;
  logic [1:0]  eng_dir = 2'b00;
  int          eng_cnt = 0;
  logic        eng_kill = 1'b0;
  logic [2:0]  rx_idx = 3'd0;
  logic [31:0] rx_words [0:7];
  logic        pop_req = 1'b0;
  logic [1:0]  sl_dir  [0:63];
  logic [1:0]  sl_lane [0:63];
  logic [15:0] sl_len  [0:63];
  logic [31:0] sl_data [0:63];
  int          seg_n = 0;
  logic [31:0] rx_log [0:31];
  int          rx_n = 0;
  int          done_cnt = 0;
  int          cs_drop = 0;

  // shift engine: accept a segment, report done two cycles later
  always @(negedge clk_i) begin
    if (pop_req) tx_rd = tx_rd + 8'd1;
    seg_done_i = 1'b0;
    if (eng_kill) begin
      eng_busy    = 1'b0;
      seg_ready_i = 1'b0;
    end else if (eng_busy) begin
      seg_ready_i = 1'b0;
      eng_cnt     = eng_cnt - 1;
      if (eng_cnt == 0) begin
        eng_busy   = 1'b0;
        seg_done_i = 1'b1;
        if (eng_dir == 2'b01) begin
          seg_rdata_i = rx_words[rx_idx];
          rx_idx      = rx_idx + 3'd1;
        end else begin
          seg_rdata_i = '0;
        end
      end
    end else if (seg_valid_o) begin
      seg_ready_i    = 1'b1;
      sl_dir[seg_n % 64]  = seg_dir_o;
      sl_lane[seg_n % 64] = seg_lane_o;
      sl_len[seg_n % 64]  = seg_len_o;
      sl_data[seg_n % 64] = seg_data_o;
      seg_n    = seg_n + 1;
      eng_dir  = seg_dir_o;
      eng_busy = 1'b1;
      eng_cnt  = 2;
    end else begin
      seg_ready_i = 1'b0;
    end
  end

  // edge monitor: pops, pushes, done pulses and CS continuity
  always @(posedge clk_i) begin
    pop_req = txf_rd_o;
    if (rxf_wr_o) begin
      rx_log[rx_n % 32] = rxf_data_o;
      rx_n = rx_n + 1;
    end
    if (done_o) done_cnt = done_cnt + 1;
    if (busy_o && !cs_o && !done_o) cs_drop = cs_drop + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input string pfx, input int idx, input logic [1:0] dir,
                         input logic [1:0] lane, input logic [15:0] len);
    chk({pfx, "_dir"},  64'(sl_dir[idx % 64]),  64'(dir));
    chk({pfx, "_lane"}, 64'(sl_lane[idx % 64]), 64'(lane));
    chk({pfx, "_len"},  64'(sl_len[idx % 64]),  64'(len));
  endtask

  task automatic set_cfg(input logic [1:0] cm, input logic [1:0] am, input logic [1:0] alm,
                         input logic [1:0] dm, input logic [1:0] as, input logic [1:0] als,
                         input logic [1:0] ds, input logic [15:0] cmd, input logic [31:0] addr,
                         input logic [15:0] nop, input logic [15:0] trl, input logic rwm);
    cmode_i = cm; amode_i = am; almode_i = alm; dmode_i = dm;
    asize_i = as; alsize_i = als; dsize_i = ds;
    cmd_i = cmd; addr_i = addr; altr_i = 32'h0; nop_i = nop; trl_i = trl; rwm_i = rwm;
  endtask

  task automatic push_tx(input logic [31:0] w);
    tx_mem[tx_wr[3:0]] = w;
    tx_wr = tx_wr + 8'd1;
  endtask

  // pulse start; returns at the falling edge of the cycle after start
  task automatic start_frame();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      if (!busy_o) break;
      @(negedge clk_i);
    end
    chk({tag, "_idle_timeout"}, 64'(busy_o), 64'd0);
    @(negedge clk_i);
  endtask

  int sb, rb, db, pb, gap_err;

  initial begin
    start_i = 1'b0; abort_i = 1'b0; rxf_full_i = 1'b0;
    set_cfg(2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 16'h0, 32'h0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) tx_mem[i] = '0;
    for (int i = 0; i < 8; i++) rx_words[i] = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy",  64'(busy_o),      64'd0);
    chk("rst_cs",    64'(cs_o),        64'd0);
    chk("rst_valid", 64'(seg_valid_o), 64'd0);
    chk("rst_done",  64'(done_o),      64'd0);
    chk("rst_rxwr",  64'(rxf_wr_o),    64'd0);
    chk("rst_len",   64'(seg_len_o),   64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: 0x9F read ID, one 24-bit std read word; upper cmd bits must not leak
    set_cfg(2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 16'h129F, 32'h0, 16'h0, 16'd1, 1'b1);
    rx_words[rx_idx] = 32'h00AB_CDEF;
    sb = seg_n; rb = rx_n; db = done_cnt;
    start_frame();
    chk("t1_busy_n1",  64'(busy_o),      64'd1);
    chk("t1_cs_n1",    64'(cs_o),        64'd1);
    chk("t1_valid_n1", 64'(seg_valid_o), 64'd1);
    wait_idle("t1");
    chk("t1_nseg", 64'(seg_n - sb), 64'd2);
    chk_seg("t1_s0", sb, 2'b00, 2'b00, 16'd8);
    chk("t1_s0_data", 64'(sl_data[sb % 64]), 64'h9F);
    chk_seg("t1_s1", sb + 1, 2'b01, 2'b00, 16'd24);
    chk("t1_npush", 64'(rx_n - rb), 64'd1);
    chk("t1_push0", 64'(rx_log[rb % 32]), 64'h00AB_CDEF);
    chk("t1_done",  64'(done_cnt - db), 64'd1);

    // 2: quad page program, 24-bit address, three 32-bit words
    set_cfg(2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 16'h0032, 32'h0000_1000, 16'h0, 16'd3, 1'b0);
    pb = tx_rd;
    push_tx(32'h1111_1111); push_tx(32'h2222_2222); push_tx(32'h3333_3333);
    sb = seg_n; db = done_cnt;
    start_frame();
    wait_idle("t2");
    chk("t2_nseg", 64'(seg_n - sb), 64'd5);
    chk("t2_s0_data", 64'(sl_data[sb % 64]), 64'h32);
    chk_seg("t2_addr", sb + 1, 2'b00, 2'b10, 16'd24);
    chk("t2_addr_data", 64'(sl_data[(sb + 1) % 64]), 64'h0000_1000);
    for (int k = 0; k < 3; k++) begin
      chk_seg($sformatf("t2_d%0d", k), sb + 2 + k, 2'b00, 2'b10, 16'd32);
      chk($sformatf("t2_d%0d_data", k), 64'(sl_data[(sb + 2 + k) % 64]),
          64'(32'h1111_1111 * (k + 1)));
    end
    chk("t2_pops", 64'(8'(tx_rd - pb)), 64'd3);
    chk("t2_done", 64'(done_cnt - db), 64'd1);
    chk("t2_csdrop", 64'(cs_drop), 64'd0);

    // 3: fast read with 8 dummy cycles; address masked to 24 bits
    set_cfg(2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 16'h006B, 32'hAB12_3456, 16'd8, 16'd1, 1'b1);
    rx_words[rx_idx] = 32'h0000_005A;
    sb = seg_n; rb = rx_n;
    start_frame();
    wait_idle("t3");
    chk("t3_nseg", 64'(seg_n - sb), 64'd4);
    chk("t3_addr_data", 64'(sl_data[(sb + 1) % 64]), 64'h0012_3456);
    chk_seg("t3_dummy", sb + 2, 2'b10, 2'b00, 16'd8);
    chk_seg("t3_data", sb + 3, 2'b01, 2'b10, 16'd8);
    chk("t3_push0", 64'(rx_log[rb % 32]), 64'h5A);

    // 4: TX FIFO runs dry for 20+ cycles between two byte writes
    set_cfg(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0, 32'h0, 16'h0, 16'd2, 1'b0);
    push_tx(32'hAABB_CCDD);
    sb = seg_n; db = done_cnt; gap_err = 0;
    start_frame();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (i >= 4 && (seg_valid_o || !cs_o || !busy_o)) gap_err++;
    end
    chk("t4_gap_hold", 64'(gap_err), 64'd0);
    chk("t4_nseg_gap", 64'(seg_n - sb), 64'd1);
    push_tx(32'h1122_3344);
    wait_idle("t4");
    chk("t4_nseg", 64'(seg_n - sb), 64'd2);
    chk("t4_d0_data", 64'(sl_data[sb % 64]), 64'hDD);
    chk("t4_d1_data", 64'(sl_data[(sb + 1) % 64]), 64'h44);
    chk("t4_done", 64'(done_cnt - db), 64'd1);

    // 5: RX FIFO full when the first word completes
    set_cfg(2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 16'h0, 32'h0, 16'h0, 16'd2, 1'b1);
    rx_words[rx_idx] = 32'h0000_1234;
    rx_words[rx_idx + 3'd1] = 32'h0000_5678;
    rxf_full_i = 1'b1;
    sb = seg_n; rb = rx_n;
    start_frame();
    repeat (10) @(negedge clk_i);
    chk("t5_nopush_full", 64'(rx_n - rb), 64'd0);
    chk("t5_hold_valid",  64'(seg_valid_o), 64'd0);
    chk("t5_hold_cs",     64'(cs_o), 64'd1);
    rxf_full_i = 1'b0;
    wait_idle("t5");
    chk("t5_npush", 64'(rx_n - rb), 64'd2);
    chk("t5_push0", 64'(rx_log[rb % 32]), 64'h1234);
    chk("t5_push1", 64'(rx_log[(rb + 1) % 32]), 64'h5678);
    chk_seg("t5_s1", sb + 1, 2'b01, 2'b01, 16'd16);

    // 6: every phase absent
    set_cfg(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0, 32'h0, 16'h0, 16'd0, 1'b0);
    sb = seg_n;
    start_frame();
    chk("t6_done_n1",  64'(done_o), 64'd1);
    chk("t6_cs_n1",    64'(cs_o), 64'd0);
    chk("t6_valid_n1", 64'(seg_valid_o), 64'd0);
    @(negedge clk_i);
    chk("t6_busy_n2",  64'(busy_o), 64'd0);
    chk("t6_nseg",     64'(seg_n - sb), 64'd0);

    // 7: abort during data word 2 of 4, then a fresh frame
    set_cfg(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 16'h0, 32'h0, 16'h0, 16'd4, 1'b0);
    pb = tx_rd;
    for (int k = 0; k < 4; k++) push_tx(32'hC0DE_0000 + 32'(k));
    sb = seg_n; db = done_cnt;
    start_frame();
    for (int i = 0; i < 100; i++) begin
      if (8'(tx_rd - pb) == 8'd2) break;
      @(negedge clk_i);
    end
    chk("t7_word2_reached", 64'(8'(tx_rd - pb)), 64'd2);
    abort_i = 1'b1; eng_kill = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("t7_abort_busy", 64'(busy_o), 64'd0);
    chk("t7_abort_cs",   64'(cs_o), 64'd0);
    repeat (6) @(negedge clk_i);
    eng_kill = 1'b0;
    chk("t7_pops",  64'(8'(tx_rd - pb)), 64'd2);
    chk("t7_nseg",  64'(seg_n - sb), 64'd2);
    chk("t7_nodone", 64'(done_cnt - db), 64'd0);
    tx_wr = tx_rd;
    set_cfg(2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 16'h00A5, 32'h0, 16'h0, 16'd0, 1'b0);
    sb = seg_n; db = done_cnt;
    start_frame();
    wait_idle("t7r");
    chk("t7r_nseg", 64'(seg_n - sb), 64'd1);
    chk("t7r_data", 64'(sl_data[sb % 64]), 64'hA5);
    chk("t7r_done", 64'(done_cnt - db), 64'd1);
    chk("all_csdrop", 64'(cs_drop), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
